// File: rtl/ext_mem_obi_arbiter.sv
// Round-robin arbiter sharing one OBI external-memory slave port among NUM_MASTERS requesters.
// Grants are zero-latency; an in-order ID FIFO routes slave responses back to the granted master.
module ext_mem_obi_arbiter #(
    parameter int NUM_MASTERS     = 2,
    parameter int MAX_OUTSTANDING = 2,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    localparam int BE_WIDTH       = DATA_WIDTH / 8
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NUM_MASTERS-1:0]            m_req_i,
    output logic [NUM_MASTERS-1:0]            m_gnt_o,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr_i,
    input  logic [NUM_MASTERS-1:0]            m_we_i,
    input  logic [NUM_MASTERS*BE_WIDTH-1:0]   m_be_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata_i,
    output logic [NUM_MASTERS-1:0]            m_rvalid_o,
    output logic [DATA_WIDTH-1:0]             m_rdata_o,
    output logic                              s_req_o,
    input  logic                              s_gnt_i,
    output logic [ADDR_WIDTH-1:0]             s_addr_o,
    output logic                              s_we_o,
    output logic [BE_WIDTH-1:0]               s_be_o,
    output logic [DATA_WIDTH-1:0]             s_wdata_o,
    input  logic                              s_rvalid_i,
    input  logic [DATA_WIDTH-1:0]             s_rdata_i,
    output logic [2:0]                        outstanding_o,
    output logic                              err_o
);

    localparam int IW = $clog2(NUM_MASTERS);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_MASTERS - 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(MAX_OUTSTANDING - 1);
    localparam logic [2:0]    MAX_CNT  = 3'(MAX_OUTSTANDING);

    typedef enum logic {LK_FREE, LK_HELD} lock_e;

    lock_e         lock_q, lock_d;
    logic [IW-1:0] lock_idx_q, lock_idx_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IW-1:0] fifo_q [MAX_OUTSTANDING];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [2:0]    count_q, count_d;
    logic          err_q, err_d;

    logic [IW-1:0] rr_idx;
    logic          rr_found;
    logic [IW-1:0] winner;
    logic          handshake;
    logic          pop;

    always_comb begin : rr_select
        int unsigned k;
        k        = 0;
        rr_idx   = rr_ptr_q;
        rr_found = 1'b0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            k = (32'(rr_ptr_q) + i) % NUM_MASTERS;
            if (!rr_found && m_req_i[k]) begin
                rr_found = 1'b1;
                rr_idx   = IW'(k);
            end
        end
    end

    // Full is judged on the registered count, so a same-cycle pop cannot open a grant.
    assign winner    = (lock_q == LK_HELD) ? lock_idx_q : rr_idx;
    assign s_req_o   = !rst_i && ((|m_req_i) || (lock_q == LK_HELD)) && (count_q < MAX_CNT);
    assign handshake = s_req_o && s_gnt_i;
    assign pop       = !rst_i && s_rvalid_i && (count_q != '0);

    always_comb begin
        s_addr_o   = '0;
        s_we_o     = 1'b0;
        s_be_o     = '0;
        s_wdata_o  = '0;
        m_gnt_o    = '0;
        m_rvalid_o = '0;
        m_rdata_o  = s_rdata_i;
        if (s_req_o) begin
            s_addr_o  = m_addr_i[winner*ADDR_WIDTH +: ADDR_WIDTH];
            s_we_o    = m_we_i[winner];
            s_be_o    = m_be_i[winner*BE_WIDTH +: BE_WIDTH];
            s_wdata_o = m_wdata_i[winner*DATA_WIDTH +: DATA_WIDTH];
            m_gnt_o[winner] = s_gnt_i;
        end
        if (pop) begin
            m_rvalid_o[fifo_q[rd_ptr_q]] = 1'b1;
        end
    end

    always_comb begin
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        rr_ptr_d   = rr_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        err_d      = err_q;
        if (handshake) begin
            lock_d   = LK_FREE;
            rr_ptr_d = (winner == LAST_IDX) ? '0 : winner + 1'b1;
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        end else if (s_req_o) begin
            lock_d     = LK_HELD;
            lock_idx_d = winner;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({handshake, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
        if (s_rvalid_i && (count_q == '0)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_q     <= LK_FREE;
            lock_idx_q <= '0;
            rr_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            rr_ptr_q   <= rr_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (handshake) begin
            fifo_q[wr_ptr_q] <= winner;
        end
    end

    assign outstanding_o = count_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_ext_mem_obi_arbiter.sv
// Randomized and directed stimulus for ext_mem_obi_arbiter against a queue-based reference model.
module tb_ext_mem_obi_arbiter;

    localparam int N    = 2;
    localparam int MAXO = 2;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int BEW  = DW / 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [N-1:0]      m_req;
    logic [N-1:0]      m_gnt;
    logic [N*AW-1:0]   m_addr;
    logic [N-1:0]      m_we;
    logic [N*BEW-1:0]  m_be;
    logic [N*DW-1:0]   m_wdata;
    logic [N-1:0]      m_rvalid;
    logic [DW-1:0]     m_rdata;
    logic              s_req;
    logic              s_gnt;
    logic [AW-1:0]     s_addr;
    logic              s_we;
    logic [BEW-1:0]    s_be;
    logic [DW-1:0]     s_wdata;
    logic              s_rvalid;
    logic [DW-1:0]     s_rdata;
    logic [2:0]        outstanding;
    logic              err;

    ext_mem_obi_arbiter #(
        .NUM_MASTERS     (N),
        .MAX_OUTSTANDING (MAXO),
        .ADDR_WIDTH      (AW),
        .DATA_WIDTH      (DW)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .m_req_i       (m_req),
        .m_gnt_o       (m_gnt),
        .m_addr_i      (m_addr),
        .m_we_i        (m_we),
        .m_be_i        (m_be),
        .m_wdata_i     (m_wdata),
        .m_rvalid_o    (m_rvalid),
        .m_rdata_o     (m_rdata),
        .s_req_o       (s_req),
        .s_gnt_i       (s_gnt),
        .s_addr_o      (s_addr),
        .s_we_o        (s_we),
        .s_be_o        (s_be),
        .s_wdata_o     (s_wdata),
        .s_rvalid_i    (s_rvalid),
        .s_rdata_i     (s_rdata),
        .outstanding_o (outstanding),
        .err_o         (err)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state: priority pointer, pending lock, in-flight master IDs in grant order.
    int rr       = 0;
    bit locked   = 1'b0;
    int lock_idx = 0;
    int idq[$];
    bit err_m    = 1'b0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic cycle(input logic [N-1:0] req, input bit gnt, input bit rv, input bit r);
        int              win;
        bit              ereq;
        bit              hs;
        bit              pop;
        logic [N-1:0]    egnt;
        logic [N-1:0]    ervalid;
        logic [AW-1:0]   ea;
        logic            ewe;
        logic [BEW-1:0]  ebe;
        logic [DW-1:0]   ewd;
        rst      = r;
        m_req    = req;
        s_gnt    = gnt;
        s_rvalid = rv;
        for (int k = 0; k < N; k++) begin
            m_addr[k*AW +: AW]    = $urandom;
            m_wdata[k*DW +: DW]   = $urandom;
            m_be[k*BEW +: BEW]    = BEW'($urandom);
            m_we[k]               = 1'($urandom);
        end
        s_rdata = $urandom;
        @(negedge clk);
        win = -1;
        if (locked) begin
            win = lock_idx;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (win < 0 && req[(rr + i) % N]) win = (rr + i) % N;
            end
        end
        ereq = !r && ((req != '0) || locked) && (idq.size() < MAXO);
        hs   = ereq && gnt;
        pop  = !r && rv && (idq.size() > 0);
        egnt    = '0;
        ervalid = '0;
        ea = '0; ewe = 1'b0; ebe = '0; ewd = '0;
        if (hs) egnt[win] = 1'b1;
        if (pop) ervalid[idq[0]] = 1'b1;
        if (ereq) begin
            ea  = m_addr[win*AW +: AW];
            ewe = m_we[win];
            ebe = m_be[win*BEW +: BEW];
            ewd = m_wdata[win*DW +: DW];
        end
        check("s_req", s_req, ereq);
        check("m_gnt", m_gnt, egnt);
        check("s_addr", s_addr, ea);
        check("s_we", s_we, ewe);
        check("s_be", s_be, ebe);
        check("s_wdata", s_wdata, ewd);
        check("m_rvalid", m_rvalid, ervalid);
        check("m_rdata", m_rdata, s_rdata);
        check("outstanding", outstanding, idq.size());
        check("err", err, err_m);
        @(posedge clk);
        if (r) begin
            rr = 0; locked = 1'b0; lock_idx = 0; err_m = 1'b0;
            idq.delete();
        end else begin
            if (rv && idq.size() == 0) err_m = 1'b1;
            if (pop) void'(idq.pop_front());
            if (hs) begin
                idq.push_back(win);
                rr     = (win + 1) % N;
                locked = 1'b0;
            end else if (ereq) begin
                locked   = 1'b1;
                lock_idx = win;
            end
        end
        #1;
    endtask

    initial begin
        rst = 1'b1; m_req = '0; s_gnt = 1'b0; s_rvalid = 1'b0;
        m_addr = '0; m_we = '0; m_be = '0; m_wdata = '0; s_rdata = '0;
        @(posedge clk); #1;
        cycle(2'b11, 1'b1, 1'b1, 1'b1);
        cycle(2'b00, 1'b0, 1'b0, 1'b1);

        // Continuous requests from both masters, response one cycle after each grant
        cycle(2'b11, 1'b1, 1'b0, 1'b0);
        repeat (8) cycle(2'b11, 1'b1, 1'b1, 1'b0);
        cycle(2'b00, 1'b0, 1'b1, 1'b0);

        // Lock holds master 1 while the slave stalls
        cycle(2'b00, 1'b0, 1'b0, 1'b1);
        cycle(2'b10, 1'b0, 1'b0, 1'b0);
        cycle(2'b11, 1'b0, 1'b0, 1'b0);
        cycle(2'b11, 1'b0, 1'b0, 1'b0);
        cycle(2'b11, 1'b1, 1'b0, 1'b0);
        cycle(2'b11, 1'b1, 1'b1, 1'b0);
        cycle(2'b00, 1'b0, 1'b1, 1'b0);

        // Fill to MAX_OUTSTANDING, then release with one response
        repeat (4) cycle(2'b11, 1'b1, 1'b0, 1'b0);
        cycle(2'b11, 1'b1, 1'b1, 1'b0);
        cycle(2'b11, 1'b1, 1'b0, 1'b0);
        cycle(2'b00, 1'b0, 1'b1, 1'b0);
        cycle(2'b00, 1'b0, 1'b1, 1'b0);

        // Unexpected response sets sticky error
        cycle(2'b00, 1'b0, 1'b0, 1'b1);
        cycle(2'b00, 1'b0, 1'b1, 1'b0);
        repeat (3) cycle(2'b11, 1'b1, 1'b1, 1'b0);

        // Reset with IDs 1 then 0 in flight; late response is unexpected
        cycle(2'b00, 1'b0, 1'b0, 1'b1);
        cycle(2'b10, 1'b1, 1'b0, 1'b0);
        cycle(2'b01, 1'b1, 1'b0, 1'b0);
        cycle(2'b00, 1'b0, 1'b0, 1'b1);
        cycle(2'b00, 1'b0, 1'b1, 1'b0);
        cycle(2'b11, 1'b1, 1'b0, 1'b0);

        // Steady push and pop at occupancy one across pointer wrap
        cycle(2'b00, 1'b0, 1'b0, 1'b1);
        cycle(2'b01, 1'b1, 1'b0, 1'b0);
        repeat (8) cycle(2'b01, 1'b1, 1'b1, 1'b0);
        cycle(2'b11, 1'b1, 1'b1, 1'b0);
        cycle(2'b00, 1'b0, 1'b1, 1'b0);

        // Random traffic with occasional resets
        cycle(2'b00, 1'b0, 1'b0, 1'b1);
        repeat (400) begin
            cycle(N'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 59) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
